// File: rtl/game_timer_pkg.sv
// -----------------------------------------------------------------------------
// game_timer_pkg
// Shared constants and types for the game's BCD time handling.
//   BCD_W / DIGITS / TIME_W : BCD digit width, digit count, packed time width
//   TICK_DIV_DEF            : CLK cycles per 1 ms on the 50 MHz board clock
//   timerState_t            : IDLE / RUN / EXPIRED encoding
//   timerReq_t              : bundled control request seen by the timer
//   TIME_ZERO, WAIT_TIME    : common BCD time constants
// -----------------------------------------------------------------------------
package game_timer_pkg;

   localparam int BCD_W        = 4;
   localparam int DIGITS       = 5;
   localparam int TIME_W       = BCD_W * DIGITS;
   localparam int TICK_DIV_DEF = 50000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } timerState_t;

   localparam logic [TIME_W-1:0] TIME_ZERO = 20'h00000;
   localparam logic [TIME_W-1:0] WAIT_TIME = 20'h04000;   // 04.000 s

   typedef struct packed {
      logic              clear;
      logic              load;
      logic [TIME_W-1:0] loadValue;
      logic              countEn;
   } timerReq_t;

endpackage

// File: rtl/bcd_digit_dec.sv
// -----------------------------------------------------------------------------
// bcd_digit_dec
// Combinational single BCD digit decrement stage plus >9 clamp.
//   digit     in  4  current digit (values >9 are treated as 9)
//   borrowIn  in  1  1 = subtract one from this digit
//   digitOut  out 4  digit after the optional decrement
//   borrowOut out 1  borrow into the next more significant digit
//   rawDigit  in  4  unclamped digit from a load value
//   clampOut  out 4  rawDigit limited to 9
// -----------------------------------------------------------------------------
module bcd_digit_dec
   import game_timer_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   input  logic             borrowIn,
   output logic [BCD_W-1:0] digitOut,
   output logic             borrowOut,
   input  logic [BCD_W-1:0] rawDigit,
   output logic [BCD_W-1:0] clampOut
);

   logic [BCD_W-1:0] digitSafe;

   always_comb begin
      digitSafe = (digit > 4'd9) ? 4'd9 : digit;
      clampOut  = (rawDigit > 4'd9) ? 4'd9 : rawDigit;
      digitOut  = digitSafe;
      borrowOut = 1'b0;
      if (borrowIn) begin
         // 0 with a borrow wraps to 9 and passes the borrow upward
         if (digitSafe == 4'd0) begin
            digitOut  = 4'd9;
            borrowOut = 1'b1;
         end else begin
            digitOut  = digitSafe - 4'd1;
         end
      end
   end

endmodule

// File: rtl/game_bcd_timer.sv
// -----------------------------------------------------------------------------
// game_bcd_timer
// Loads a 5-digit BCD time (xx.xxx s) and counts it down in 1 ms steps.
//   CLK       in  1   system clock
//   RST       in  1   synchronous active-low reset
//   clear     in  1   abort to IDLE, zero count, no expiry pulse
//   load      in  1   capture loadValue (digits clamped to 9) and start
//   loadValue in  20  BCD {tens, ones, tenths, hundredths, thousandths}
//   countEn   in  1   1 = count, 0 = pause (prescaler and value hold)
//   timeLeft  out 20  remaining BCD time, registered
//   running   out 1   high while in RUN
//   expired   out 1   one-cycle pulse when the count reaches 00.000
//   warn      out 1   low-time flag (RUN and < 01.000)
// Optional feature macro: GAME_TIMER_WARN_EN (undefined: warn tied low).
// Priority per edge: RST > clear > load > tick.
// -----------------------------------------------------------------------------
module game_bcd_timer
   import game_timer_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int DIGITS   = 5
)(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    clear,
   input  logic                    load,
   input  logic [DIGITS*BCD_W-1:0] loadValue,
   input  logic                    countEn,
   output logic [DIGITS*BCD_W-1:0] timeLeft,
   output logic                    running,
   output logic                    expired,
   output logic                    warn
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   timerReq_t   req;
   timerState_t state, stateNxt;
   logic [PW-1:0] pre, preNxt;
   logic [DIGITS*BCD_W-1:0] timeNxt;
   logic expNxt;

   logic [DIGITS-1:0][BCD_W-1:0] curDig, decDig, rawDig, clampDig;
   logic [DIGITS:0]              borrow;
   logic [DIGITS*BCD_W-1:0]      decVal, clampVal;

   assign req = '{clear: clear, load: load, loadValue: loadValue, countEn: countEn};

   // ---------------------------------------------------------------------------
   // BCD ripple: digit 0 is thousandths, always decremented on a tick
   // ---------------------------------------------------------------------------
   assign curDig    = timeLeft;
   assign rawDig    = req.loadValue;
   assign borrow[0] = 1'b1;

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : gDig
         bcd_digit_dec uDig (
            .digit    (curDig[i]),
            .borrowIn (borrow[i]),
            .digitOut (decDig[i]),
            .borrowOut(borrow[i+1]),
            .rawDigit (rawDig[i]),
            .clampOut (clampDig[i])
         );
      end
   endgenerate

   assign decVal   = decDig;
   assign clampVal = clampDig;

   // ---------------------------------------------------------------------------
   // State / datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= IDLE;
         timeLeft <= TIME_ZERO;
         pre      <= '0;
         running  <= 1'b0;
         expired  <= 1'b0;
      end else begin
         state    <= stateNxt;
         timeLeft <= timeNxt;
         pre      <= preNxt;
         running  <= (stateNxt == RUN);
         expired  <= expNxt;
      end
   end

   always_comb begin
      stateNxt = state;
      timeNxt  = timeLeft;
      preNxt   = pre;
      expNxt   = 1'b0;
      if (req.clear) begin
         stateNxt = IDLE;
         timeNxt  = TIME_ZERO;
         preNxt   = '0;
      end else if (req.load) begin
         // a tick coinciding with load is dropped: the count restarts
         timeNxt = clampVal;
         preNxt  = '0;
         if (clampVal == TIME_ZERO) begin
            stateNxt = EXPIRED;
            expNxt   = 1'b1;
         end else begin
            stateNxt = RUN;
         end
      end else begin
         case (state)
            RUN: begin
               if (req.countEn) begin
                  if (pre == PRE_LAST) begin
                     preNxt  = '0;
                     timeNxt = decVal;
                     if (decVal == TIME_ZERO) begin
                        stateNxt = EXPIRED;
                        expNxt   = 1'b1;
                     end
                  end else begin
                     preNxt = pre + 1'b1;
                  end
               end
            end
            IDLE:    preNxt = '0;
            default: ;   // EXPIRED holds until load/clear
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Low-time warning, aligned with the registered state and value
   // ---------------------------------------------------------------------------
`ifdef GAME_TIMER_WARN_EN
   always_ff @(posedge CLK) begin
      if (!RST)
         warn <= 1'b0;
      else
         warn <= (stateNxt == RUN) && (timeNxt[DIGITS*BCD_W-1:3*BCD_W] == '0);
   end
`else
   assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_bcd_timer.sv
// -----------------------------------------------------------------------------
// tb_game_bcd_timer
// Scoreboard bench: the driver updates an integer-millisecond reference model
// each cycle and queues the expected outputs; a monitor pops and compares
// after every rising edge.
// -----------------------------------------------------------------------------
module tb_game_bcd_timer;

   localparam int TICK = 4;

   typedef struct packed {
      logic [19:0] t;
      logic        r;
      logic        e;
      logic        w;
   } expect_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        clear = 1'b0;
   logic        load = 1'b0;
   logic [19:0] loadValue = 20'h0;
   logic        countEn = 1'b0;
   logic [19:0] timeLeft;
   logic        running, expired, warn;

   game_bcd_timer #(.TICK_DIV(TICK), .DIGITS(5)) dut (
      .CLK(CLK), .RST(RST), .clear(clear), .load(load),
      .loadValue(loadValue), .countEn(countEn),
      .timeLeft(timeLeft), .running(running), .expired(expired), .warn(warn)
   );

   always #5 CLK = ~CLK;

   expect_t q[$];
   int  nCmp = 0;
   int  nErr = 0;
   int  cyc  = 0;
   bit  done = 1'b0;

   // reference model: remaining time as plain milliseconds
   int  mMs  = 0;
   int  mPre = 0;
   bit  mRun = 1'b0;
   bit  mExp = 1'b0;

   function automatic int bcdToInt(input logic [19:0] v);
      int s = 0;
      for (int k = 4; k >= 0; k--) begin
         int d = int'(v[k*4 +: 4]);
         if (d > 9) d = 9;
         s = s * 10 + d;
      end
      return s;
   endfunction

   function automatic logic [19:0] intToBcd(input int ms);
      logic [19:0] v = '0;
      int x = ms;
      for (int k = 0; k < 5; k++) begin
         v[k*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return v;
   endfunction

   task automatic drive(input bit rst, input bit clr, input bit ld,
                        input logic [19:0] lv, input bit en);
      expect_t x;
      RST = rst; clear = clr; load = ld; loadValue = lv; countEn = en;
      if (!rst || clr) begin
         mMs = 0; mPre = 0; mRun = 0; mExp = 0;
      end else if (ld) begin
         mMs = bcdToInt(lv); mPre = 0;
         mRun = (mMs != 0); mExp = (mMs == 0);
      end else begin
         mExp = 0;
         if (mRun && en) begin
            mPre++;
            if (mPre == TICK) begin
               mPre = 0;
               mMs--;
               if (mMs == 0) begin mRun = 0; mExp = 1; end
            end
         end
      end
      x.t = intToBcd(mMs);
      x.r = mRun;
      x.e = mExp;
`ifdef GAME_TIMER_WARN_EN
      x.w = mRun && (mMs < 1000);
`else
      x.w = 1'b0;
`endif
      q.push_back(x);
      @(negedge CLK);
   endtask

   task automatic idle(input int n, input bit en);
      for (int k = 0; k < n; k++) drive(1, 0, 0, 20'h0, en);
   endtask

   task automatic ldv(input logic [19:0] v);
      drive(1, 0, 1, v, 1);
   endtask

   // monitor
   initial begin
      expect_t x;
      forever begin
         @(posedge CLK);
         #1;
         cyc++;
         if (q.size() == 0) begin
            if (!done) begin
               nCmp++; nErr++;
               $display("FAIL underflow cycle %0d: no expected entry queued", cyc);
            end
         end else begin
            x = q.pop_front();
            nCmp++;
            if (timeLeft !== x.t || running !== x.r || expired !== x.e || warn !== x.w) begin
               nErr++;
               $display("FAIL cycle %0d: got t=%h run=%b exp=%b warn=%b, want t=%h run=%b exp=%b warn=%b",
                        cyc, timeLeft, running, expired, warn, x.t, x.r, x.e, x.w);
            end
         end
      end
   end

   // driver
   initial begin
      logic [19:0] rv;
      drive(0, 0, 0, 20'h0, 0);
      idle(0, 0);
      drive(0, 0, 0, 20'h0, 1);
      drive(0, 0, 0, 20'h0, 1);
      idle(3, 1);                          // IDLE ignores countEn
      ldv(20'h00003); idle(16, 1);         // 3 -> 0, expiry pulse
      ldv(20'h10000); idle(5, 1);          // 10.000 -> 09.999
      ldv(20'h00100); idle(5, 1);          // 00.100 -> 00.099
      ldv(20'h00005); idle(2, 1); idle(10, 0); idle(6, 1);  // pause/resume
      ldv(20'h00000); idle(3, 1);          // immediate expiry
      ldv(20'h0A00F); idle(3, 1);          // clamp -> 09009
      ldv(20'h00050); idle(6, 1);
      drive(1, 1, 1, 20'h00020, 1); idle(3, 1);  // clear beats load
      ldv(20'h00050); idle(3, 1);
      ldv(20'h00040); idle(5, 1);          // load on a tick cycle
      ldv(20'h00050); idle(5, 1);
      drive(0, 0, 0, 20'h0, 1); drive(0, 0, 1, 20'h00007, 1); idle(2, 1);  // reset mid-count
      ldv(20'h01001); idle(TICK * 1001 + 4, 1);  // warn threshold and expiry
      // randomized phase
      for (int k = 0; k < 1500; k++) begin
         int r = $urandom_range(0, 199);
         bit en = ($urandom_range(0, 9) < 8);
         if (r == 0) drive(0, 0, 0, 20'h0, en);
         else if (r < 4) drive(1, 1, $urandom_range(0, 1), 20'h00010, en);
         else if (r < 14) begin
            rv = 20'($urandom);
            if ($urandom_range(0, 3) != 0) rv[19:8] = 12'h0;
            if ($urandom_range(0, 3) == 0) rv[19:12] = 8'h01;
            drive(1, 0, 1, rv, en);
         end else drive(1, 0, 0, 20'h0, en);
      end
      done = 1'b1;
      repeat (3) @(posedge CLK);
      #2;
      if (q.size() != 0) begin
         nCmp++; nErr++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
